// File: rtl/reg_file_mp.sv
// reg_file_mp: parametrised multi-port register file with hardwired-zero R0,
// a clear-on-reset sweep (INIT -> RUN) and a per-register pending scoreboard.
// Optional feature macro: REG_FILE_BYPASS_EN enables same-cycle write-to-read
// forwarding; when it is undefined, written values appear one cycle later.
module reg_file_mp #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 3,
    parameter int NUM_RD   = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic                     ready,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_pend
);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_idx;
    logic [ADDR_W-1:0]   w_idx_nxt;
    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_pend;
    logic                w_run;
    logic                w_wr_ok;
    logic                w_rsv_ok;

    // State and sweep-index register; reset restarts the clear sweep.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_INIT;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Next-state logic: walk every index once, then enter RUN.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        if (r_state == ST_INIT) begin
            w_idx_nxt = r_idx + 1'b1;
            if (r_idx == LAST_IDX) begin
                w_state_nxt = ST_RUN;
            end
        end
    end

    assign w_run    = (r_state == ST_RUN);
    assign ready    = w_run;
    assign w_wr_ok  = w_run && wr_en  && (wr_addr  != '0);
    assign w_rsv_ok = w_run && rsv_en && (rsv_addr != '0);

    // Register array: zeroed by the INIT sweep, written by writeback in RUN.
    always_ff @(posedge clk) begin
        // NOTE: the array carries no reset term; the INIT sweep clears it one entry per cycle.
        if (rst_n) begin
            if (r_state == ST_INIT) begin
                r_regs[r_idx] <= '0;
            end else if (w_wr_ok) begin
                r_regs[wr_addr] <= wr_data;
            end
        end
    end

    // Pending scoreboard: writeback clears, decode reservation sets.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pend <= '0;
        end else begin
            if (w_wr_ok) begin
                r_pend[wr_addr] <= 1'b0;
            end
            // NOTE: the later non-blocking assignment wins, so a same-address reservation overrides the clear.
            if (w_rsv_ok) begin
                r_pend[rsv_addr] <= 1'b1;
            end
        end
    end

    // Combinational read ports; R0 and all ports during INIT read as zero.
    always_comb begin
        logic [ADDR_W-1:0] w_ra;
        w_ra    = '0;
        rd_data = '0;
        rd_pend = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            w_ra = rd_addr[k*ADDR_W +: ADDR_W];
            if (w_run && (w_ra != '0)) begin
                rd_data[k*DATA_W +: DATA_W] = r_regs[w_ra];
                rd_pend[k]                  = r_pend[w_ra];
`ifdef REG_FILE_BYPASS_EN
                if (w_wr_ok && (w_ra == wr_addr)) begin
                    rd_data[k*DATA_W +: DATA_W] = wr_data;
                    rd_pend[k]                  = w_rsv_ok && (rsv_addr == wr_addr);
                end
`else
`endif
            end
        end
    end

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-port register file for the simple RISC core, the next generation of the fixed 8×16, two-read-port register file. It adds configurable width, depth and read-port count, a hardwired-zero R0, a sequential clear-on-reset sweep and a per-register pending scoreboard for hazard detection. It sits between decode (read addresses, destination reservation) and writeback (write port).

## Interface
Parameters:
- DATA_W, 16, register width in bits
- NUM_REGS, 8, register count; power of two, ≥ 2
- ADDR_W, 3, address width; equals log2(NUM_REGS)
- NUM_RD, 2, number of read ports; ≥ 1

Ports:
- clk  in  1  single clock; all state changes on rising edge
- rst_n  in  1  synchronous, active-low reset
- ready  out  1  high once the clear sweep is complete
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  write destination
- wr_data  in  DATA_W  write value
- rsv_en  in  1  reserve (mark pending) strobe from decode
- rsv_addr  in  ADDR_W  register to mark pending
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port k occupies bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data; port k occupies bits [k*DATA_W +: DATA_W]
- rd_pend  out  NUM_RD  pending bit of the register addressed by each port

## Operation
- Two states: INIT and RUN.
- Reset: rst_n low at an edge forces state to INIT, sweep index to 0, ready to 0, and all pending bits to 0.
- INIT: each edge with rst_n high writes 0 to regs[idx] and increments idx. The edge on which idx == NUM_REGS-1 moves the block to RUN and sets ready to 1.
- INIT side effects:
  - wr_en and rsv_en are ignored.
  - rd_data is 0 on all ports.
  - rd_pend is 0 on all ports.
- RUN, write: wr_en with wr_addr ≠ 0 stores wr_data and clears pend[wr_addr].
- RUN, reservation: rsv_en with rsv_addr ≠ 0 sets pend[rsv_addr].
- Same address, same cycle: if wr_en and rsv_en target the same address, the data is written and pend stays/becomes 1 (the reservation wins).
- R0: reads always return 0 with pending 0. Writes and reservations to R0 are discarded.
- Reads are combinational: rd_data[k] = regs[rd_addr[k]], and rd_pend[k] = pend[rd_addr[k]].
- Any number of ports may read the same address.
- Out-of-range addresses cannot occur because ADDR_W = log2(NUM_REGS).

## Timing
- Reset values:
  - ready = 0
  - rd_data = 0
  - rd_pend = 0
  - state INIT
- ready rises exactly NUM_REGS rising edges after the first edge sampling rst_n high (8 for defaults).
- Reset mid-operation (including mid-sweep) restarts INIT from idx 0. All contents and pending bits are lost.
- Write latency: the stored value is visible on rd_data from the cycle after the write edge, unless bypass is compiled in.
- Reservation latency: pend is visible on rd_pend the cycle after the rsv_en edge. There is never a same-cycle bypass of reservations.
- Writes to the same register on consecutive cycles: the last write wins. No back-pressure exists.

## Configuration
- REG_FILE_BYPASS_EN defined: write-to-read forwarding is enabled. In RUN, when wr_en = 1, wr_addr ≠ 0 and rd_addr[k] == wr_addr:
  - rd_data[k] = wr_data in the same cycle.
  - rd_pend[k] = 0, unless rsv_en targets the same address that cycle, in which case it is 1.
- Not defined: no forwarding. Reads return array contents and stored pending bits only, which gives one cycle of write-to-read latency.

## Test plan
- Reset sweep: hold rst_n low for 3 cycles, then release → ready = 0 for 8 edges and 1 after the 8th. All rd_data = 0 during and after the sweep.
- Write/read: write R1 = 0x0005 and R2 = 0x0003, then read R1 and R2 on ports 0 and 1 → 0x0005 and 0x0003 the next cycle. Write R0 = 0xFFFF → reads 0x0000.
- Scoreboard: reserve R3 → rd_pend for R3 is 1 next cycle. Write R3 = 0x00AA → pend 0 and data 0x00AA next cycle. Write and reserve R4 in the same cycle → pend 1, data updated.
- Bypass: read R5 while writing R5 = 0x1234.
  - With REG_FILE_BYPASS_EN: rd_data = 0x1234 in the same cycle.
  - Without it: old value in the same cycle, 0x1234 next cycle.
- Mid-operation reset: write R6 = 0x7777, reserve R7, then pulse rst_n low for 1 cycle during RUN → ready drops, then re-rises after 8 edges. R6 reads 0 and R7 pend is 0. Writes issued during INIT have no effect.
- Parameter sweep: DATA_W = 32, NUM_REGS = 16, ADDR_W = 4, NUM_RD = 3 → sweep takes 16 edges. Three ports reading R15 all return the last written value.
